// File: rtl/freq_lock_pkg.sv
// Shared definitions for the frequency lock detector.
//   state_t     : FSM state encoding (IDLE, MEASURE, LOCKED)
//   *_DEF       : default values for CNT_W, TOL and LOCK_N
package freq_lock_pkg;

    localparam int CNT_W_DEF  = 8;
    localparam int TOL_DEF    = 1;
    localparam int LOCK_N_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_LOCKED  = 2'd2
    } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Three-flop synchronizer with rising-edge detect for an asynchronous input.
//   clk      : sampling clock
//   rst_n    : asynchronous active-low reset
//   async_in : signal asynchronous to clk
//   rise     : high for one clk cycle after a synchronized 0->1 transition
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic rise
);

    logic s1, s2, s3;

    // s1/s2 resolve metastability; s3 is the delayed copy for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/freq_lock_det.sv
// Frequency lock detector: measures the period of div_in in clk cycles and
// declares lock after LOCK_N consecutive periods within TOL of exp_period.
//   clk, rst_n  : system clock, asynchronous active-low reset
//   en          : measurement enable (low returns to IDLE)
//   div_in      : divided clock under test (asynchronous)
//   exp_period  : expected period in clk cycles
//   period      : last measured period (held between updates)
//   period_vld  : one-cycle pulse when a new period has been evaluated
//   locked      : high while in LOCKED
//   timeout     : one-cycle pulse when the period counter saturates
module freq_lock_det
    import freq_lock_pkg::*;
#(
    parameter int CNT_W  = CNT_W_DEF,
    parameter int TOL    = TOL_DEF,
    parameter int LOCK_N = LOCK_N_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             div_in,
    input  logic [CNT_W-1:0] exp_period,
    output logic [CNT_W-1:0] period,
    output logic             period_vld,
    output logic             locked,
    output logic             timeout
);

    localparam int MW = $clog2(LOCK_N + 1);

    logic             rise;
    logic [CNT_W-1:0] cnt;
    logic             sat;
    logic [CNT_W:0]   diff;
    logic             in_win;
    logic             pend;      // period captured last cycle, evaluate now
    logic [MW-1:0]    match_cnt;
    state_t           state;

    sync_edge_det u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (div_in),
        .rise     (rise)
    );

    assign sat = &cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else if (rise)
            cnt <= CNT_W'(1);
        else if (!sat)
            cnt <= cnt + 1'b1;
    end

    // |period - exp_period| in CNT_W+1 bits so the subtraction never wraps.
    always_comb begin
        diff = '0;
        if (period >= exp_period)
            diff = {1'b0, period} - {1'b0, exp_period};
        else
            diff = {1'b0, exp_period} - {1'b0, period};
    end

    assign in_win = (diff <= (CNT_W+1)'(TOL));

    // Edge cycle captures the period; the following cycle compares it
    // against exp_period, so locked and period_vld change together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            match_cnt  <= '0;
            period     <= '0;
            period_vld <= 1'b0;
            locked     <= 1'b0;
            timeout    <= 1'b0;
            pend       <= 1'b0;
        end else begin
            period_vld <= 1'b0;
            timeout    <= 1'b0;
            pend       <= 1'b0;
            if (!en) begin
                state     <= ST_IDLE;
                match_cnt <= '0;
                locked    <= 1'b0;
            end else begin
                unique case (state)
                    ST_IDLE: begin
                        if (rise) begin
                            state     <= ST_MEASURE;
                            match_cnt <= '0;
                        end
                    end
                    ST_MEASURE, ST_LOCKED: begin
                        if (pend) begin
                            period_vld <= 1'b1;
                            if (state == ST_MEASURE) begin
                                if (!in_win)
                                    match_cnt <= '0;
                                else if (match_cnt == MW'(LOCK_N - 1)) begin
                                    state     <= ST_LOCKED;
                                    locked    <= 1'b1;
                                    match_cnt <= '0;
                                end else
                                    match_cnt <= match_cnt + 1'b1;
                            end else if (!in_win) begin
                                state     <= ST_MEASURE;
                                match_cnt <= '0;
                                locked    <= 1'b0;
                            end
                        end
                        // An edge wins over saturation in the same cycle.
                        if (rise) begin
                            period <= cnt;
                            pend   <= 1'b1;
                        end else if (sat) begin
                            timeout   <= 1'b1;
                            state     <= ST_IDLE;
                            match_cnt <= '0;
                            locked    <= 1'b0;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/freq_lock_det.md
FREQ_LOCK_DET -- requirements
Module: freq_lock_det

Interface
REQ-001 Parameter CNT_W, 8, width of the period counter and period output.
REQ-002 Parameter TOL, 1, allowed |measured - expected| period error, in clk cycles.
REQ-003 Parameter LOCK_N, 4, consecutive in-window periods required to declare lock.
REQ-004 Port clk  input  1  single system clock; all state on the rising edge.
REQ-005 Port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 Port en  input  1  measurement enable; low forces IDLE on the next clk edge.
REQ-007 Port div_in  input  1  divided clock under test, asynchronous to clk.
REQ-008 Port exp_period  input  CNT_W  expected div_in period in clk cycles, sampled every cycle.
REQ-009 Port period  output  CNT_W  last measured period, held between updates.
REQ-010 Port period_vld  output  1  one-cycle pulse when period updates.
REQ-011 Port locked  output  1  high while in LOCKED.
REQ-012 Port timeout  output  1  one-cycle pulse when the counter saturates with no edge.

Function
REQ-013 The block shall pass div_in through a 3-flop chain (s1, s2, s3) and detect a rising edge as s2 & ~s3.
REQ-014 The period counter shall load 1 on an edge, increment by 1 otherwise, and saturate at 2^CNT_W-1.
REQ-015 On an edge in MEASURE or LOCKED, period shall take the counter value and period_vld shall pulse on the next cycle.
REQ-016 Latency: period_vld shall assert 3 clk edges after the first clk edge that samples div_in high, with +1 cycle synchronizer uncertainty.
REQ-017 The FSM states shall be IDLE, MEASURE and LOCKED.
REQ-018 IDLE: no period_vld; the first edge with en=1 shall go to MEASURE with match_cnt=0.
REQ-019 MEASURE: an in-window period, |period-exp_period| <= TOL with unsigned CNT_W+1-bit arithmetic, shall increment match_cnt.
REQ-020 MEASURE: an out-of-window period shall clear match_cnt.
REQ-021 MEASURE: when match_cnt reaches LOCK_N, the FSM shall go to LOCKED.
REQ-022 LOCKED: an out-of-window period shall go to MEASURE with match_cnt=0; locked shall fall in the same cycle that period_vld pulses.
REQ-023 Counter saturation in MEASURE or LOCKED shall pulse timeout for one cycle, go to IDLE and clear locked and match_cnt.
REQ-024 An edge and saturation in the same cycle shall be treated as an edge, with no timeout.
REQ-025 en=0 shall take priority over edge and timeout: go to IDLE, clear match_cnt and locked, and hold period.
REQ-026 A change in exp_period shall affect only the comparisons made after it.

Reset
REQ-027 rst_n low shall immediately clear s1..s3, the counter, match_cnt, period, period_vld, locked and timeout, and set state IDLE.
REQ-028 Reset release shall need no further initialisation; the first edge after release shall not produce period_vld.

Structure
REQ-029 Package freq_lock_pkg shall hold the state enum and the default values of CNT_W, TOL and LOCK_N.
REQ-030 The synchronizer and edge detector shall be a sub-module, sync_edge_det (ports: clk, rst_n, async_in, rise).
REQ-031 The FSM, counter and comparator shall reside in freq_lock_det.

Verification (CNT_W=8, TOL=1, LOCK_N=4, exp_period=8, en=1)
REQ-032 Reset check: assert rst_n mid-cycle -> all outputs 0 immediately; the first div_in rise after release produces no period_vld.
REQ-033 Lock acquisition: div_in period 8 clk -> period_vld with period=8 from the 2nd edge; locked rises at the 5th edge and stays high.
REQ-034 Tolerance window: while locked, periods 9 and 7 -> locked stays high; period 10 -> period=10, locked falls with that period_vld.
REQ-035 Timeout: stop div_in while locked -> one timeout pulse when the counter reaches 255, locked=0, IDLE, no period_vld.
REQ-036 Enable mid-lock: drop en for 1 cycle -> IDLE, locked=0, period held; restart needs a first edge plus 4 matches before locked.
REQ-037 Reset mid-measure: pulse rst_n low after 2 matches -> match_cnt cleared; lock takes the full 5 edges again.
